// File: rtl/scroll_sequencer.sv
// -----------------------------------------------------------------------------
// scroll_sequencer
//
// Frame-driven horizontal scroll controller for a foreground layer. Raw VGA
// vsync is synchronized and edge-detected into one frame event per vsync
// rise. The sequence waits DELAY_FRAMES frames, then slides hoffset left by
// STEP per frame until it lands exactly on LIMIT. It holds there for
// HOLD_FRAMES frames, then either loops back to the delay (LOOP=1) or parks
// in DONE (LOOP=0).
//
// Ports
//   CLK100MHZ   in   sole clock, rising edge
//   CPU_RESETN  in   asynchronous active-low reset
//   vsync       in   raw vertical sync, asynchronous to CLK100MHZ
//   start       in   level; launches from IDLE or relaunches from DONE
//   pause       in   level; freezes the sequence, frame events are dropped
//   hoffset     out  signed 12-bit horizontal layer offset (registered)
//   frame_tick  out  one-cycle pulse per detected frame (registered)
//   busy        out  high in DELAY, SCROLL and HOLD
//   done        out  high in DONE
// -----------------------------------------------------------------------------
module scroll_sequencer #(
   parameter int DELAY_FRAMES = 45,
   parameter int STEP         = 5,
   parameter int LIMIT        = -600,
   parameter int HOLD_FRAMES  = 60,
   parameter int LOOP         = 0
) (
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   input  logic               vsync,
   input  logic               start,
   input  logic               pause,
   output logic signed [11:0] hoffset,
   output logic               frame_tick,
   output logic               busy,
   output logic               done
);

   // Counter wide enough to hold the larger frame count plus one.
   localparam int MAX_FRAMES = (DELAY_FRAMES > HOLD_FRAMES) ? DELAY_FRAMES : HOLD_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 2);

   localparam logic [CNT_W-1:0]  DELAY_C = CNT_W'(DELAY_FRAMES);
   localparam logic [CNT_W-1:0]  HOLD_C  = CNT_W'(HOLD_FRAMES);
   localparam logic signed [12:0] STEP_C  = 13'(STEP);
   localparam logic signed [12:0] LIMIT13 = 13'(LIMIT);
   localparam logic signed [11:0] LIMIT12 = 12'(LIMIT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_SCROLL,
      ST_HOLD,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------- sync
   logic       vsync_meta_q, vsync_meta_d;
   logic       vsync_sync_q, vsync_sync_d;
   logic       vsync_prev_q, vsync_prev_d;
   logic [2:0] sync_valid_q, sync_valid_d;
   logic       frame_tick_q, frame_tick_d;
   logic       frame_evt;

   // sync_valid_q marks how far real vsync samples have propagated since
   // reset release. An edge is only trusted once both the current and the
   // previous synchronized values are real samples, so the cleared reset
   // value never masquerades as a low level and a vsync that is already high
   // at release cannot create a frame.
   assign frame_evt = vsync_sync_q & ~vsync_prev_q & sync_valid_q[2];

   always_comb begin
      vsync_meta_d = vsync;
      vsync_sync_d = vsync_meta_q;
      vsync_prev_d = vsync_sync_q;
      sync_valid_d = {sync_valid_q[1:0], 1'b1};
      frame_tick_d = frame_evt;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         vsync_meta_q <= 1'b0;
         vsync_sync_q <= 1'b0;
         vsync_prev_q <= 1'b0;
         sync_valid_q <= 3'b000;
         frame_tick_q <= 1'b0;
      end else begin
         vsync_meta_q <= vsync_meta_d;
         vsync_sync_q <= vsync_sync_d;
         vsync_prev_q <= vsync_prev_d;
         sync_valid_q <= sync_valid_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic signed [11:0]   hoffset_q, hoffset_d;
   logic [CNT_W-1:0]     cnt_inc;
   logic signed [12:0]   scroll_diff;
   logic                 frame_go;

   assign cnt_inc = cnt_q + CNT_W'(1);
   // One extra bit so the subtraction cannot wrap before the clamp compare.
   assign scroll_diff = {hoffset_q[11], hoffset_q} - STEP_C;
   // Pause swallows a coinciding frame event; nothing is queued for later.
   assign frame_go = frame_evt & ~pause;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hoffset_d = hoffset_q;
      case (state_q)
         ST_IDLE: begin
            hoffset_d = '0;
            // start is honoured regardless of pause here
            if (start) begin
               state_d = ST_DELAY;
               cnt_d   = '0;
            end
         end
         ST_DELAY: begin
            if (frame_go) begin
               // ">=" also covers DELAY_FRAMES=0: leave on the first frame
               if (cnt_inc >= DELAY_C) begin
                  state_d = ST_SCROLL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_SCROLL: begin
            if (frame_go) begin
               if (scroll_diff <= LIMIT13) begin
                  hoffset_d = LIMIT12;
                  state_d   = ST_HOLD;
                  cnt_d     = '0;
               end else begin
                  hoffset_d = scroll_diff[11:0];
               end
            end
         end
         ST_HOLD: begin
            if (frame_go) begin
               if (cnt_inc >= HOLD_C) begin
                  cnt_d = '0;
                  if (LOOP != 0) begin
                     state_d   = ST_DELAY;
                     hoffset_d = '0;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_DONE: begin
            hoffset_d = LIMIT12;
            if (start) begin
               state_d   = ST_DELAY;
               hoffset_d = '0;
               cnt_d     = '0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hoffset_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hoffset_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hoffset_q <= hoffset_d;
      end
   end

   // Outputs come straight from flops; busy/done are a decode of state_q only.
   assign hoffset    = hoffset_q;
   assign frame_tick = frame_tick_q;
   assign busy       = (state_q == ST_DELAY) || (state_q == ST_SCROLL) || (state_q == ST_HOLD);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_scroll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scroll_sequencer
//
// Four parameterizations of scroll_sequencer share one clock, reset and
// stimulus. A frame-level reference model tracks each one and every output
// is compared on every falling clock edge; a set of literal checks pins key
// values (latency, delay length, scroll steps, pause, clamp, reset).
// -----------------------------------------------------------------------------
module tb_scroll_sequencer;

   localparam int NI = 4;
   localparam int P_DELAY [NI] = '{45, 3, 2, 0};
   localparam int P_STEP  [NI] = '{5, 7, 5, 3};
   localparam int P_LIMIT [NI] = '{-600, -20, -10, -7};
   localparam int P_HOLD  [NI] = '{60, 4, 1, 2};
   localparam int P_LOOP  [NI] = '{0, 0, 1, 1};

   localparam int PH_IDLE   = 0;
   localparam int PH_DELAY  = 1;
   localparam int PH_SCROLL = 2;
   localparam int PH_HOLD   = 3;
   localparam int PH_DONE   = 4;

   logic clk;
   logic rst_n;
   logic vsync;
   logic start;
   logic pause;

   logic signed [11:0] hoff_w [NI];
   logic               tick_w [NI];
   logic               busy_w [NI];
   logic               done_w [NI];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      scroll_sequencer #(
         .DELAY_FRAMES (P_DELAY[gi]),
         .STEP         (P_STEP[gi]),
         .LIMIT        (P_LIMIT[gi]),
         .HOLD_FRAMES  (P_HOLD[gi]),
         .LOOP         (P_LOOP[gi])
      ) u_dut (
         .CLK100MHZ  (clk),
         .CPU_RESETN (rst_n),
         .vsync      (vsync),
         .start      (start),
         .pause      (pause),
         .hoffset    (hoff_w[gi]),
         .frame_tick (tick_w[gi]),
         .busy       (busy_w[gi]),
         .done       (done_w[gi])
      );
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Frame detection: a frame happens at the edge where the vsync sample
   // taken two edges earlier is 1 and the one taken three edges earlier is 0,
   // counting only samples taken since reset release.
   typedef struct packed {
      int phase;
      int cnt;
      int hoff;
   } mst_t;

   mst_t     m_st [NI];
   logic [2:0] m_hist;      // [0] = previous edge's sample, [2] = three edges ago
   int       m_hcnt;
   logic     m_tick;
   logic     m_evt;

   assign m_evt = (m_hcnt >= 3) && m_hist[1] && !m_hist[2];

   function automatic mst_t model_next(mst_t s, int i, logic evt, logic st, logic pz);
      mst_t n = s;
      int   nh;
      if (s.phase == PH_IDLE || s.phase == PH_DONE) begin
         if (st) begin
            n.phase = PH_DELAY;
            n.cnt   = 0;
            n.hoff  = 0;
         end
      end else if (evt && !pz) begin
         n.cnt = s.cnt + 1;
         if (s.phase == PH_DELAY) begin
            if (n.cnt >= P_DELAY[i]) begin
               n.phase = PH_SCROLL;
               n.cnt   = 0;
            end
         end else if (s.phase == PH_SCROLL) begin
            n.cnt  = 0;
            nh     = s.hoff - P_STEP[i];
            n.hoff = (nh < P_LIMIT[i]) ? P_LIMIT[i] : nh;
            if (n.hoff == P_LIMIT[i]) n.phase = PH_HOLD;
         end else begin
            if (n.cnt >= P_HOLD[i]) begin
               n.cnt = 0;
               if (P_LOOP[i] != 0) begin
                  n.phase = PH_DELAY;
                  n.hoff  = 0;
               end else begin
                  n.phase = PH_DONE;
               end
            end
         end
      end
      return n;
   endfunction

   initial begin
      for (int i = 0; i < NI; i++) m_st[i] = '{PH_IDLE, 0, 0};
      m_hist = 3'b000;
      m_hcnt = 0;
      m_tick = 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) m_st[i] <= '{PH_IDLE, 0, 0};
         m_hist <= 3'b000;
         m_hcnt <= 0;
         m_tick <= 1'b0;
      end else begin
         for (int i = 0; i < NI; i++) m_st[i] <= model_next(m_st[i], i, m_evt, start, pause);
         m_hist <= {m_hist[1:0], vsync};
         m_hcnt <= (m_hcnt < 3) ? m_hcnt + 1 : m_hcnt;
         m_tick <= m_evt;
      end
   end

   // --------------------------------------------------- per-cycle compare
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d_hoffset", i), int'(hoff_w[i]), m_st[i].hoff);
         chk($sformatf("u%0d_busy", i), int'(busy_w[i]),
             int'(m_st[i].phase == PH_DELAY || m_st[i].phase == PH_SCROLL || m_st[i].phase == PH_HOLD));
         chk($sformatf("u%0d_done", i), int'(done_w[i]), int'(m_st[i].phase == PH_DONE));
         chk($sformatf("u%0d_frame_tick", i), int'(tick_w[i]), int'(m_tick));
      end
   end

   // ------------------------------------------------------------ monitors
   int                 tick_total = 0;
   int                 u0_min = 0;
   int                 u1_seq [$];
   logic signed [11:0] u1_last = '0;
   logic signed [11:0] u2_prev = '0;
   int                 u2_loops = 0;
   logic               u2_done_seen = 1'b0;

   always @(negedge clk) begin
      if (tick_w[0]) tick_total <= tick_total + 1;
      if (int'(hoff_w[0]) < u0_min) u0_min <= int'(hoff_w[0]);
      if (hoff_w[1] != u1_last) begin
         if (hoff_w[1] != 0 && u1_seq.size() < 3) u1_seq.push_back(int'(hoff_w[1]));
         u1_last <= hoff_w[1];
      end
      if (u2_prev == -10 && hoff_w[2] == 0) u2_loops <= u2_loops + 1;
      u2_prev <= hoff_w[2];
      if (done_w[2]) u2_done_seen <= 1'b1;
   end

   // ------------------------------------------------------------ stimulus
   // One vsync period of random length; optional start noise and a random
   // pause change at a random cycle inside the frame.
   task automatic frame(input bit noise, input bit rpause);
      int h   = $urandom_range(3, 6);
      int l   = $urandom_range(3, 6);
      int pat = $urandom_range(0, h + l - 1);
      bit pv  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      vsync = 1'b1;
      for (int c = 0; c < h + l; c++) begin
         if (c == h) vsync = 1'b0;
         if (noise && c == 1) start = ($urandom_range(0, 3) == 0);
         if (noise && c == 2) start = 1'b0;
         if (rpause && c == pat) pause = pv;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int lat;
      int t0;
      int n;
      vsync = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_hoffset", int'(hoff_w[0]), 0);
      chk("reset_busy", int'(busy_w[0]), 0);
      chk("reset_done", int'(done_w[0]), 0);
      chk("reset_tick", int'(tick_w[0]), 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // frame_tick latency, measured in IDLE where frames are ignored
      t0  = tick_total;
      lat = 0;
      vsync = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (tick_w[0] && lat == 0) lat = k;
      end
      @(negedge clk);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      chk("tick_latency_edges", lat, 3);
      chk("tick_one_pulse_per_rise", tick_total - t0, 1);
      chk("idle_ignores_frames", int'(busy_w[0]), 0);

      // launch; 45 delay frames with start noise
      pulse_start();
      chk("start_busy", int'(busy_w[0]), 1);
      for (int k = 0; k < 45; k++) frame(1'b1, 1'b0);
      chk("delay45_hoffset", int'(hoff_w[0]), 0);
      chk("delay45_busy", int'(busy_w[0]), 1);
      frame(1'b0, 1'b0);
      chk("frame46_hoffset", int'(hoff_w[0]), -5);
      frame(1'b0, 1'b0);
      chk("frame47_hoffset", int'(hoff_w[0]), -10);
      for (int k = 0; k < 18; k++) frame(1'b0, 1'b0);
      chk("scroll_at_m100", int'(hoff_w[0]), -100);

      // pause for 10 rises
      pause = 1'b1;
      t0 = tick_total;
      for (int k = 0; k < 10; k++) frame(1'b0, 1'b0);
      pause = 1'b0;
      chk("pause_ticks", tick_total - t0, 10);
      chk("pause_hoffset", int'(hoff_w[0]), -100);
      frame(1'b0, 1'b0);
      chk("after_pause_hoffset", int'(hoff_w[0]), -105);

      // randomized pause and start noise
      for (int k = 0; k < 40; k++) frame(1'b1, 1'b1);
      pause = 1'b0;

      // run to HOLD, then count hold frames
      n = 0;
      while (hoff_w[0] != -600 && n < 300) begin
         frame(1'b0, 1'b0);
         n++;
      end
      chk("u0_reach_hold", int'(hoff_w[0]), -600);
      n = 0;
      while (!done_w[0] && n < 100) begin
         frame(1'b0, 1'b0);
         n++;
      end
      chk("u0_hold_frames", n, 60);
      chk("u0_done", int'(done_w[0]), 1);
      for (int k = 0; k < 3; k++) frame(1'b0, 1'b0);
      chk("done_hoffset_stays", int'(hoff_w[0]), -600);
      chk("u0_never_below_limit", u0_min, -600);

      // start with pause high in DONE still relaunches
      @(negedge clk);
      pause = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
      chk("relaunch_busy", int'(busy_w[0]), 1);
      chk("relaunch_done", int'(done_w[0]), 0);
      chk("relaunch_hoffset", int'(hoff_w[0]), 0);

      chk("u1_seq_len", u1_seq.size(), 3);
      if (u1_seq.size() == 3) begin
         chk("u1_seq0", u1_seq[0], -7);
         chk("u1_seq1", u1_seq[1], -14);
         chk("u1_seq2", u1_seq[2], -20);
      end
      chk("u2_never_done", int'(u2_done_seen), 0);
      chk("u2_looped", int'(u2_loops > 0), 1);

      // back into HOLD, then reset asynchronously mid-HOLD
      n = 0;
      while (hoff_w[0] != -600 && n < 300) begin
         frame(1'b0, 1'b0);
         n++;
      end
      frame(1'b0, 1'b0);
      chk("hold_before_reset_busy", int'(busy_w[0]), 1);
      @(negedge clk);
      vsync = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_hoffset", int'(hoff_w[0]), 0);
      chk("async_reset_busy", int'(busy_w[0]), 0);
      chk("async_reset_done", int'(done_w[0]), 0);
      t0 = tick_total;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_tick_vsync_high_at_release", tick_total - t0, 0);
      vsync = 1'b0;
      repeat (4) @(negedge clk);
      t0 = tick_total;
      frame(1'b0, 1'b0);
      chk("tick_after_release", tick_total - t0, 1);
      pulse_start();
      for (int k = 0; k < 8; k++) frame(1'b1, 1'b1);
      pause = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 SHALL provide parameter DELAY_FRAMES, default 45, number of frames spent in DELAY before scrolling.
REQ-002 SHALL provide parameter STEP, default 5, positive per-frame hoffset decrement.
REQ-003 SHALL provide parameter LIMIT, default -600, signed final hoffset value (LIMIT <= 0).
REQ-004 SHALL provide parameter HOLD_FRAMES, default 60, frames spent in HOLD at LIMIT.
REQ-005 SHALL provide parameter LOOP, default 0; 1 = return to DELAY after HOLD, 0 = stop in DONE.
REQ-006 CLK100MHZ  input  1  sole clock; all state changes on its rising edge.
REQ-007 CPU_RESETN  input  1  asynchronous active-low reset.
REQ-008 vsync  input  1  raw VGA vertical sync from the timing generator, asynchronous to this block's sampling.
REQ-009 start  input  1  level; launches or relaunches the sequence.
REQ-010 pause  input  1  level; freezes the sequence while high.
REQ-011 hoffset  output  12 signed  horizontal layer offset fed to the foreground address transformer.
REQ-012 frame_tick  output  1  one-cycle pulse per detected frame.
REQ-013 busy  output  1  high in DELAY, SCROLL and HOLD.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 SHALL pass vsync through a two-flop synchronizer; a frame event SHALL be a 0->1 transition of the synchronized value.
REQ-016 frame_tick SHALL be registered, high for exactly one cycle, asserted on the 3rd CLK100MHZ rising edge after vsync rises (setup met); each vsync rise SHALL produce exactly one pulse.
REQ-017 State machine states SHALL be IDLE, DELAY, SCROLL, HOLD and DONE, with busy and done decoded from the registered state.
REQ-018 IDLE: hoffset=0; start=1 SHALL move to DELAY on the next edge with frame counter cleared; frame events are ignored.
REQ-019 DELAY: each frame event SHALL increment the frame counter; on the event making count equal DELAY_FRAMES, SHALL move to SCROLL with counter cleared; DELAY_FRAMES=0 SHALL move to SCROLL on the first frame event.
REQ-020 SCROLL: on each frame event, hoffset SHALL be set to hoffset-STEP, computed in 13-bit signed arithmetic.
REQ-021 SCROLL clamp: if hoffset-STEP <= LIMIT, hoffset SHALL equal LIMIT exactly and the state SHALL move to HOLD on the same edge; hoffset SHALL never go below LIMIT.
REQ-022 HOLD: SHALL count HOLD_FRAMES frame events at hoffset=LIMIT; on the final one, SHALL go to DELAY with hoffset=0 if LOOP=1, else to DONE.
REQ-023 DONE: hoffset SHALL hold LIMIT; start=1 SHALL move to DELAY with hoffset=0 and counter cleared.
REQ-024 start SHALL be ignored in DELAY, SCROLL and HOLD.
REQ-025 While pause=1, state, counter and hoffset SHALL not change, and frame events SHALL be discarded (not queued); frame_tick SHALL still pulse.
REQ-026 If pause and a frame event coincide, pause SHALL win.
REQ-027 If start and pause are both high in IDLE or DONE, the start transition SHALL still occur.
REQ-028 hoffset, busy and done SHALL be registered outputs with no combinational path from any input.

Reset
REQ-029 CPU_RESETN=0 SHALL immediately force the state to IDLE, hoffset=0, counter=0, frame_tick=0, busy=0, done=0, and clear the synchronizer flops, regardless of state.
REQ-030 After release, the first frame event SHALL require a synchronized 0->1 transition; vsync already high at release SHALL NOT produce a frame_tick.

Verification
REQ-031 Defaults, start pulse, 45 vsync rises -> busy=1, hoffset=0 throughout DELAY; the 46th rise gives hoffset=-5; the 47th gives -10.
REQ-032 Defaults, run through SCROLL -> hoffset steps 0,-5,...,-600 over 120 scroll frames, enters HOLD at -600, never -605; after 60 more frames done=1 and hoffset stays -600.
REQ-033 STEP=7, LIMIT=-20 -> hoffset sequence -7,-14,-20, then HOLD.
REQ-034 pause high for 10 vsync rises mid-SCROLL at -100 -> hoffset stays -100 and 10 frame_tick pulses occur; the next rise after pause drops gives -105.
REQ-035 CPU_RESETN low mid-HOLD -> same cycle hoffset=0, busy=0, done=0; vsync held high through release gives no frame_tick.
REQ-036 LOOP=1, DELAY_FRAMES=2, HOLD_FRAMES=1, LIMIT=-10 -> hoffset cycles 0,0,-5,-10,-10,0,... with done never asserted.
